// File: rtl/sn74169_ctrl_pkg.sv
// sn74169_ctrl_pkg: state encoding and command codes for the sn74169 control sequencer
package sn74169_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_LOAD = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;
endpackage

// File: rtl/sn74169_ctrl_if.sv
// sn74169_ctrl_if: command handshake plus sn74169 pin bundle, suffixes seen from the controller
interface sn74169_ctrl_if #(parameter int DIV_W = 8, parameter int TCC_W = 8);
  logic             cmd_valid_i;
  logic [1:0]       cmd_i;
  logic             cmd_ready_o;
  logic [3:0]       preset_i;
  logic             dir_i;
  logic             auto_i;
  logic [DIV_W-1:0] div_i;
  logic             rcob_i;
  logic [3:0]       a_o;
  logic             u_db_o;
  logic             enpb_o;
  logic             entb_o;
  logic             loadb_o;
  logic             busy_o;
  logic             tc_pulse_o;
  logic [TCC_W-1:0] tc_cnt_o;
  modport master (
    output cmd_valid_i, cmd_i, preset_i, dir_i, auto_i, div_i, rcob_i,
    input  cmd_ready_o, a_o, u_db_o, enpb_o, entb_o, loadb_o, busy_o, tc_pulse_o, tc_cnt_o
  );
  modport slave (
    input  cmd_valid_i, cmd_i, preset_i, dir_i, auto_i, div_i, rcob_i,
    output cmd_ready_o, a_o, u_db_o, enpb_o, entb_o, loadb_o, busy_o, tc_pulse_o, tc_cnt_o
  );
endinterface

// File: rtl/sn74169_ctrl_prescaler.sv
// sn74169_prescaler: count-rate down-counter, tick when zero, reloads with div on tick
module sn74169_prescaler #(parameter int DIV_W = 8) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == '0;
  always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick_o ? div_i : cnt_q - DIV_W'(1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sn74169_ctrl.sv
// sn74169_ctrl: load/run/stop sequencer, prescaled count enables and auto-reload for an sn74169
module sn74169_ctrl
  import sn74169_ctrl_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int TCC_W = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  sn74169_ctrl_if.slave bus
);
  state_t           state_q, state_d;
  logic [3:0]       a_q;
  logic             dir_q, auto_q, tc_pulse_q;
  logic [DIV_W-1:0] div_q;
  logic [TCC_W-1:0] tc_cnt_q;
  logic             ready, accept, run, tick, term, cap, cap_run;
  assign ready   = state_q != LOAD;
  assign accept  = bus.cmd_valid_i & ready;
  assign run     = state_q == RUN;
  assign cap     = accept & (bus.cmd_i == CMD_LOAD || bus.cmd_i == CMD_RUN);
  assign cap_run = accept & (bus.cmd_i == CMD_RUN);
  assign term    = run & tick & ~bus.rcob_i;
  always_comb
    state_d = state_q == LOAD        ? IDLE :
              !accept                ? state_q :
              bus.cmd_i == CMD_LOAD  ? LOAD :
              bus.cmd_i == CMD_RUN   ? RUN :
              bus.cmd_i == CMD_STOP  ? IDLE : state_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      a_q    <= '0;
      dir_q  <= 1'b1;
      auto_q <= 1'b0;
      div_q  <= '0;
    end else begin
      if (cap) begin
        a_q   <= bus.preset_i;
        dir_q <= bus.dir_i;
      end
      if (cap_run) begin
        auto_q <= bus.auto_i;
        div_q  <= bus.div_i;
      end
    end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      tc_pulse_q <= 1'b0;
      tc_cnt_q   <= '0;
    end else begin
      tc_pulse_q <= term;
      tc_cnt_q   <= tc_cnt_q + TCC_W'(term);
    end
  sn74169_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cap_run),
    .en_i  (run),
    .div_i (div_q),
    .tick_o(tick)
  );
  // Auto-reload takes the place of the wrap edge; load wins over count in the counter.
  assign bus.loadb_o     = ~(state_q == LOAD | (term & auto_q));
  assign bus.enpb_o      = ~(run & tick);
  assign bus.entb_o      = ~(run & tick);
  assign bus.cmd_ready_o = ready;
  assign bus.a_o         = a_q;
  assign bus.u_db_o      = dir_q;
  assign bus.busy_o      = run;
  assign bus.tc_pulse_o  = tc_pulse_q;
  assign bus.tc_cnt_o    = tc_cnt_q;
endmodule

// File: tb/tb_sn74169_ctrl.sv
// tb_sn74169_ctrl: directed bench, controller driving a behavioural sn74169 with RCOB fed back
module tb_sn74169_ctrl;
  import sn74169_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] q = 4'd0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sn74169_ctrl_if #(.DIV_W(8), .TCC_W(8)) bus ();
  sn74169_ctrl #(.DIV_W(8), .TCC_W(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  assign bus.rcob_i = ~(~bus.entb_o & (bus.u_db_o ? q == 4'd15 : q == 4'd0));
  always @(posedge clk)
    if (!bus.loadb_o) q <= bus.a_o;
    else if (!bus.enpb_o && !bus.entb_o) q <= bus.u_db_o ? q + 4'd1 : q - 4'd1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] c, input logic [3:0] p, input logic d, input logic au, input logic [7:0] dv);
    bus.cmd_i = c; bus.preset_i = p; bus.dir_i = d; bus.auto_i = au; bus.div_i = dv;
    bus.cmd_valid_i = 1'b1;
    step();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_i = CMD_NOP;
  endtask
  task automatic test_reset();
    logic [18:0] got;
    step();
    got = {bus.a_o, bus.u_db_o, bus.enpb_o, bus.entb_o, bus.loadb_o, bus.cmd_ready_o, bus.busy_o, bus.tc_pulse_o, bus.tc_cnt_o};
    checks++; if (got !== {4'd0, 7'b1111100, 8'd0}) begin errors++; $display("FAIL reset_outputs: got %h expected %h", got, {4'd0, 7'b1111100, 8'd0}); end
    rst = 1'b0;
    issue(CMD_LOAD, 4'd5, 1'b1, 1'b0, 8'd0);
    checks++; if (bus.loadb_o !== 1'b0) begin errors++; $display("FAIL reset_pre_loadb: got %b expected 0", bus.loadb_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.loadb_o !== 1'b1) begin errors++; $display("FAIL reset_async_loadb: got %b expected 1", bus.loadb_o); end
    checks++; if (bus.cmd_ready_o !== 1'b1) begin errors++; $display("FAIL reset_async_ready: got %b expected 1", bus.cmd_ready_o); end
    step();
    checks++; if (q !== 4'd0) begin errors++; $display("FAIL reset_no_load: got %0d expected 0", q); end
    checks++; if (bus.tc_cnt_o !== 8'd0 || bus.a_o !== 4'd0) begin errors++; $display("FAIL reset_regs: got tc=%0d a=%0d expected 0 0", bus.tc_cnt_o, bus.a_o); end
    #2 rst = 1'b0;
  endtask
  task automatic test_load();
    step();
    issue(CMD_LOAD, 4'd9, 1'b1, 1'b0, 8'd0);
    checks++; if ({bus.loadb_o, bus.enpb_o, bus.cmd_ready_o} !== 3'b010) begin errors++; $display("FAIL load_window: got loadb,enpb,ready=%b expected 010", {bus.loadb_o, bus.enpb_o, bus.cmd_ready_o}); end
    checks++; if ({bus.a_o, bus.u_db_o} !== {4'd9, 1'b1}) begin errors++; $display("FAIL load_pins: got a=%0d u=%b expected 9 1", bus.a_o, bus.u_db_o); end
    step();
    checks++; if (q !== 4'd9) begin errors++; $display("FAIL load_q: got %0d expected 9", q); end
    checks++; if ({bus.loadb_o, bus.cmd_ready_o, bus.busy_o} !== 3'b110) begin errors++; $display("FAIL load_idle: got loadb,ready,busy=%b expected 110", {bus.loadb_o, bus.cmd_ready_o, bus.busy_o}); end
  endtask
  task automatic test_auto_reload();
    issue(CMD_LOAD, 4'd12, 1'b1, 1'b0, 8'd0);
    step();
    issue(CMD_RUN, 4'd12, 1'b1, 1'b1, 8'd0);
    for (int i = 0; i <= 12; i++) begin
      checks++; if (q !== 4'(12 + i % 4)) begin errors++; $display("FAIL auto_q[%0d]: got %0d expected %0d", i, q, 12 + i % 4); end
      checks++; if (bus.tc_cnt_o !== 8'(i / 4)) begin errors++; $display("FAIL auto_tccnt[%0d]: got %0d expected %0d", i, bus.tc_cnt_o, i / 4); end
      checks++; if (bus.tc_pulse_o !== (i > 0 && i % 4 == 0)) begin errors++; $display("FAIL auto_pulse[%0d]: got %b", i, bus.tc_pulse_o); end
      if (i < 12) step();
    end
  endtask
  task automatic test_stop_on_terminal();
    repeat (3) step();
    checks++; if ({q, bus.loadb_o} !== {4'd15, 1'b0}) begin errors++; $display("FAIL stop_pre: got q=%0d loadb=%b expected 15 0", q, bus.loadb_o); end
    issue(CMD_STOP, 4'd0, 1'b1, 1'b0, 8'd0);
    checks++; if (q !== 4'd12) begin errors++; $display("FAIL stop_reload: got %0d expected 12", q); end
    checks++; if ({bus.tc_cnt_o, bus.tc_pulse_o} !== {8'd4, 1'b1}) begin errors++; $display("FAIL stop_tc: got cnt=%0d pulse=%b expected 4 1", bus.tc_cnt_o, bus.tc_pulse_o); end
    checks++; if ({bus.enpb_o, bus.busy_o, bus.cmd_ready_o} !== 3'b101) begin errors++; $display("FAIL stop_idle: got enpb,busy,ready=%b expected 101", {bus.enpb_o, bus.busy_o, bus.cmd_ready_o}); end
    step();
    checks++; if ({q, bus.tc_pulse_o} !== {4'd12, 1'b0}) begin errors++; $display("FAIL stop_hold: got q=%0d pulse=%b expected 12 0", q, bus.tc_pulse_o); end
  endtask
  task automatic test_down_prescale();
    int exp_q [10] = '{1, 0, 0, 0, 15, 15, 15, 14, 14, 14};
    issue(CMD_LOAD, 4'd1, 1'b0, 1'b0, 8'd0);
    step();
    checks++; if ({q, bus.u_db_o} !== {4'd1, 1'b0}) begin errors++; $display("FAIL down_load: got q=%0d u=%b expected 1 0", q, bus.u_db_o); end
    issue(CMD_RUN, 4'd1, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 10; i++) begin
      checks++; if (q !== 4'(exp_q[i])) begin errors++; $display("FAIL down_q[%0d]: got %0d expected %0d", i, q, exp_q[i]); end
      checks++; if (bus.enpb_o !== (i % 3 != 0)) begin errors++; $display("FAIL down_enpb[%0d]: got %b", i, bus.enpb_o); end
      checks++; if (bus.tc_pulse_o !== (i == 4)) begin errors++; $display("FAIL down_pulse[%0d]: got %b", i, bus.tc_pulse_o); end
      checks++; if (bus.tc_cnt_o !== 8'(i >= 4 ? 5 : 4)) begin errors++; $display("FAIL down_tccnt[%0d]: got %0d expected %0d", i, bus.tc_cnt_o, i >= 4 ? 5 : 4); end
      if (i < 9) step();
    end
    issue(CMD_STOP, 4'd0, 1'b1, 1'b0, 8'd0);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL down_stop: got busy=%b expected 0", bus.busy_o); end
  endtask
  task automatic test_tc_wrap();
    issue(CMD_LOAD, 4'd15, 1'b1, 1'b0, 8'd0);
    step();
    issue(CMD_RUN, 4'd15, 1'b1, 1'b1, 8'd0);
    repeat (250) step();
    checks++; if ({bus.tc_cnt_o, q} !== {8'd255, 4'd15}) begin errors++; $display("FAIL wrap_255: got cnt=%0d q=%0d expected 255 15", bus.tc_cnt_o, q); end
    step();
    checks++; if ({bus.tc_cnt_o, bus.tc_pulse_o} !== {8'd0, 1'b1}) begin errors++; $display("FAIL wrap_zero: got cnt=%0d pulse=%b expected 0 1", bus.tc_cnt_o, bus.tc_pulse_o); end
    bus.cmd_i = CMD_LOAD; bus.preset_i = 4'd3; bus.dir_i = 1'b1; bus.cmd_valid_i = 1'b1;
    step();
    checks++; if ({bus.cmd_ready_o, bus.loadb_o, bus.busy_o} !== 3'b000) begin errors++; $display("FAIL busy_load: got ready,loadb,busy=%b expected 000", {bus.cmd_ready_o, bus.loadb_o, bus.busy_o}); end
    bus.cmd_i = CMD_RUN; bus.preset_i = 4'd7;
    step();
    bus.cmd_valid_i = 1'b0;
    checks++; if ({bus.busy_o, bus.cmd_ready_o, bus.a_o} !== {2'b01, 4'd3}) begin errors++; $display("FAIL busy_reject: got busy=%b ready=%b a=%0d expected 0 1 3", bus.busy_o, bus.cmd_ready_o, bus.a_o); end
    checks++; if ({q, bus.tc_cnt_o} !== {4'd3, 8'd1}) begin errors++; $display("FAIL busy_q: got q=%0d cnt=%0d expected 3 1", q, bus.tc_cnt_o); end
  endtask
  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_i = CMD_NOP; bus.preset_i = 4'd0;
    bus.dir_i = 1'b1; bus.auto_i = 1'b0; bus.div_i = 8'd0;
    test_reset();
    test_load();
    test_auto_reload();
    test_stop_on_terminal();
    test_down_prescale();
    test_tc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
